// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and limits for the stopwatch seconds source.
// Imported by the debouncer and the stopwatch top.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] ONE_MAX = 4'd9;
  localparam logic [2:0] TEN_MAX = 3'd5;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, level debouncer and press pulse
// for one raw push-button.
module btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 20_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  // press is registered alongside the level flip
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
        press <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear stopwatch producing registered BCD
// seconds 00-59 for the seven-segment display stage.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned DEB_CYCLES = 20_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] bcd_one,
  output logic [2:0] bcd_ten,
  output logic       running,
  output logic       step,
  output logic       wrap
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST =
    PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    one_d;
  logic [2:0]    ten_d;
  logic          step_d, wrap_d;
  logic          ss_p, clr_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ss (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_ss),
    .press (ss_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clr),
    .press (clr_p)
  );

  // clear has priority over a same-cycle start/stop press
  always_comb begin
    state_d = state_q;
    if (clr_p) begin
      state_d = ST_IDLE;
    end else if (ss_p) begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pre_d  = pre_q;
    one_d  = bcd_one;
    ten_d  = bcd_ten;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (clr_p) begin
      pre_d = '0;
      one_d = '0;
      ten_d = '0;
    end else if (state_q == ST_RUN) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        step_d = 1'b1;
        if (bcd_one == ONE_MAX) begin
          one_d = '0;
          if (bcd_ten == TEN_MAX) begin
            ten_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ten_d = bcd_ten + 3'd1;
          end
        end else begin
          one_d = bcd_one + 4'd1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else if (state_q == ST_IDLE) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      bcd_one <= '0;
      bcd_ten <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      bcd_one <= one_d;
      bcd_ten <= ten_d;
      step    <= step_d;
      wrap    <= wrap_d;
      running <= (state_d == ST_RUN);
    end
  end

endmodule
